// File: rtl/dmi_stage_fifo.sv
// Staging FIFO for DMI responses: circular buffer with optional empty-buffer bypass.
// Flow control is valid/ready on both sides; occupancy flags come from registered state only.
module dmi_stage_fifo #(
  parameter int unsigned DATA_W       = 34,
  parameter int unsigned DEPTH        = 2,
  parameter bit          FALL_THROUGH = 1'b0,
  parameter int unsigned CNT_W        = $clog2(DEPTH + 1)
) (
  input  logic              tck_i,
  input  logic              trst_i,
  input  logic              flush_i,
  input  logic [DATA_W-1:0] in_data_i,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  output logic [DATA_W-1:0] out_data_o,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [CNT_W-1:0]  count_o,
  output logic              full_o,
  output logic              empty_o
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PTR_W-1:0] LastPtr = PTR_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0] FullCnt = CNT_W'(DEPTH);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;

  logic bypass;
  logic push, pop;
  logic do_write, do_read;

  // Pointers wrap explicitly so non-power-of-two depths keep order.
  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] ptr);
    return (ptr == LastPtr) ? '0 : ptr + 1'b1;
  endfunction

  // Handshake decode and output muxing; bypass only while the buffer is empty.
  always_comb begin
    full_o     = (count_q == FullCnt);
    empty_o    = (count_q == '0);
    count_o    = count_q;
    bypass     = FALL_THROUGH && empty_o;
    in_ready_o = !flush_i && (!full_o || out_ready_i);
    if (bypass) begin
      out_valid_o = in_valid_i && !flush_i;
      out_data_o  = in_data_i;
    end else begin
      out_valid_o = !empty_o && !flush_i;
      out_data_o  = mem_q[rd_ptr_q];
    end
    push     = in_valid_i && in_ready_o;
    pop      = out_valid_o && out_ready_i;
    // A bypassed word that is consumed at once never touches storage.
    do_write = push && !(bypass && pop);
    do_read  = pop && !bypass;
  end

  // Next-state for pointers and occupancy; flush overrides everything.
  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_write) wr_ptr_d = next_ptr(wr_ptr_q);
      if (do_read)  rd_ptr_d = next_ptr(rd_ptr_q);
      if (do_write && !do_read) begin
        count_d = count_q + 1'b1;
      end else if (do_read && !do_write) begin
        count_d = count_q - 1'b1;
      end
    end
  end

  // Pointer and occupancy registers.
  always_ff @(posedge tck_i or posedge trst_i) begin
    if (trst_i) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage array, cleared on reset so the output reads zero afterwards.
  always_ff @(posedge tck_i or posedge trst_i) begin
    if (trst_i) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_q[i] <= '0;
      end
    end else if (do_write) begin
      mem_q[wr_ptr_q] <= in_data_i;
    end
  end

endmodule

// File: tb/tb_dmi_stage_fifo.sv
// Directed bench for dmi_stage_fifo: depth-2 registered, depth-3 registered, depth-2 bypass.
module tb_dmi_stage_fifo;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_pass  = 0;
  int   n_total = 0;

  always #5 clk = ~clk;

  // Depth 2, registered output.
  logic        a_flush = 1'b0, a_in_valid = 1'b0, a_out_ready = 1'b0;
  logic [33:0] a_in_data = '0;
  logic        a_in_ready, a_out_valid, a_full, a_empty;
  logic [33:0] a_out_data;
  logic [1:0]  a_count;

  dmi_stage_fifo #(.DATA_W(34), .DEPTH(2), .FALL_THROUGH(1'b0)) u_a (
    .tck_i(clk), .trst_i(rst), .flush_i(a_flush),
    .in_data_i(a_in_data), .in_valid_i(a_in_valid), .in_ready_o(a_in_ready),
    .out_data_o(a_out_data), .out_valid_o(a_out_valid), .out_ready_i(a_out_ready),
    .count_o(a_count), .full_o(a_full), .empty_o(a_empty)
  );

  // Depth 3, registered output (non-power-of-two wrap).
  logic        b_flush = 1'b0, b_in_valid = 1'b0, b_out_ready = 1'b0;
  logic [33:0] b_in_data = '0;
  logic        b_in_ready, b_out_valid, b_full, b_empty;
  logic [33:0] b_out_data;
  logic [1:0]  b_count;

  dmi_stage_fifo #(.DATA_W(34), .DEPTH(3), .FALL_THROUGH(1'b0)) u_b (
    .tck_i(clk), .trst_i(rst), .flush_i(b_flush),
    .in_data_i(b_in_data), .in_valid_i(b_in_valid), .in_ready_o(b_in_ready),
    .out_data_o(b_out_data), .out_valid_o(b_out_valid), .out_ready_i(b_out_ready),
    .count_o(b_count), .full_o(b_full), .empty_o(b_empty)
  );

  // Depth 2, fall-through.
  logic        c_flush = 1'b0, c_in_valid = 1'b0, c_out_ready = 1'b0;
  logic [33:0] c_in_data = '0;
  logic        c_in_ready, c_out_valid, c_full, c_empty;
  logic [33:0] c_out_data;
  logic [1:0]  c_count;

  dmi_stage_fifo #(.DATA_W(34), .DEPTH(2), .FALL_THROUGH(1'b1)) u_c (
    .tck_i(clk), .trst_i(rst), .flush_i(c_flush),
    .in_data_i(c_in_data), .in_valid_i(c_in_valid), .in_ready_o(c_in_ready),
    .out_data_o(c_out_data), .out_valid_o(c_out_valid), .out_ready_i(c_out_ready),
    .count_o(c_count), .full_o(c_full), .empty_o(c_empty)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Fixed downstream-ready pattern for the streaming run, one bit per cycle.
  logic [39:0] rdy_pat = 40'b1011_0010_1110_0110_1001_1100_0101_1011_0111_0010;

  initial begin
    int wi;
    int ri;
    int cyc;

    // Reset state.
    #2;
    check("rst_count", 64'(a_count), 64'd0);
    check("rst_empty", 64'(a_empty), 64'd1);
    check("rst_full", 64'(a_full), 64'd0);
    check("rst_valid", 64'(a_out_valid), 64'd0);
    check("rst_ready", 64'(a_in_ready), 64'd1);
    check("rst_data", 64'(a_out_data), 64'd0);
    #10 rst = 1'b0;
    tick();

    // Fill depth-2 with 0x1, 0x2 while downstream stalls.
    a_in_valid = 1'b1; a_in_data = 34'h1; a_out_ready = 1'b0;
    #1 check("fill1_ready", 64'(a_in_ready), 64'd1);
    check("fill1_valid_lat", 64'(a_out_valid), 64'd0);
    tick();
    check("fill1_count", 64'(a_count), 64'd1);
    check("fill1_valid", 64'(a_out_valid), 64'd1);
    check("fill1_data", 64'(a_out_data), 64'h1);
    a_in_data = 34'h2;
    tick();
    a_in_data = 34'h7;
    #1 check("full_flag", 64'(a_full), 64'd1);
    check("full_count", 64'(a_count), 64'd2);
    check("full_ready", 64'(a_in_ready), 64'd0);
    tick();
    check("stall_hold_data", 64'(a_out_data), 64'h1);
    check("stall_hold_count", 64'(a_count), 64'd2);

    // Drain in order.
    a_in_valid = 1'b0; a_out_ready = 1'b1;
    #1 check("pop1_data", 64'(a_out_data), 64'h1);
    tick();
    check("pop2_data", 64'(a_out_data), 64'h2);
    check("pop2_count", 64'(a_count), 64'd1);
    tick();
    check("drained_empty", 64'(a_empty), 64'd1);
    check("drained_valid", 64'(a_out_valid), 64'd0);

    // Refill, then push 0x3 and pop 0x1 together while full.
    a_out_ready = 1'b0; a_in_valid = 1'b1; a_in_data = 34'h1;
    tick();
    a_in_data = 34'h2;
    tick();
    a_in_data = 34'h3; a_out_ready = 1'b1;
    #1 check("fullpp_ready", 64'(a_in_ready), 64'd1);
    check("fullpp_data", 64'(a_out_data), 64'h1);
    tick();
    a_in_valid = 1'b0;
    #1 check("fullpp_count", 64'(a_count), 64'd2);
    check("fullpp_next", 64'(a_out_data), 64'h2);
    tick();
    check("fullpp_last", 64'(a_out_data), 64'h3);
    tick();
    check("fullpp_empty", 64'(a_empty), 64'd1);

    // Flush with count 2 and a pending push.
    a_out_ready = 1'b0; a_in_valid = 1'b1; a_in_data = 34'h4;
    tick();
    a_in_data = 34'h5;
    tick();
    check("preflush_count", 64'(a_count), 64'd2);
    a_flush = 1'b1; a_in_data = 34'h6;
    #1 check("flush_ready", 64'(a_in_ready), 64'd0);
    check("flush_valid", 64'(a_out_valid), 64'd0);
    tick();
    a_flush = 1'b0; a_in_valid = 1'b0;
    #1 check("postflush_count", 64'(a_count), 64'd0);
    check("postflush_empty", 64'(a_empty), 64'd1);

    // Reset pulse mid-transfer with one word held.
    a_in_valid = 1'b1; a_in_data = 34'h9;
    tick();
    a_in_valid = 1'b0;
    #1 check("prerst_count", 64'(a_count), 64'd1);
    #2 rst = 1'b1;
    #1 check("midrst_valid", 64'(a_out_valid), 64'd0);
    check("midrst_count", 64'(a_count), 64'd0);
    check("midrst_data", 64'(a_out_data), 64'd0);
    #1 rst = 1'b0;
    tick();
    a_in_valid = 1'b1; a_in_data = 34'h5;
    tick();
    a_in_valid = 1'b0; a_out_ready = 1'b1;
    #1 check("postrst_first", 64'(a_out_data), 64'h5);
    check("postrst_valid", 64'(a_out_valid), 64'd1);
    tick();
    check("postrst_empty", 64'(a_empty), 64'd1);
    a_out_ready = 1'b0;

    // Depth-3 stream of 0x10..0x19 against an irregular ready pattern.
    wi = 0; ri = 0; cyc = 0;
    while ((ri < 10) && (cyc < 40)) begin
      b_in_valid  = (wi < 10);
      b_in_data   = 34'(32'h10 + wi);
      b_out_ready = rdy_pat[cyc];
      #1 check("stream_count", 64'(b_count), 64'(wi - ri));
      if (b_out_valid && b_out_ready) begin
        check("stream_data", 64'(b_out_data), 64'(32'h10 + ri));
        ri++;
      end
      if (b_in_valid && b_in_ready) wi++;
      tick();
      cyc++;
    end
    b_in_valid = 1'b0; b_out_ready = 1'b0;
    check("stream_delivered", 64'(ri), 64'd10);
    check("stream_end_empty", 64'(b_empty), 64'd1);

    // Fall-through: empty bypass with immediate consumption.
    c_in_valid = 1'b1; c_in_data = 34'hAA; c_out_ready = 1'b1;
    #1 check("ft_valid", 64'(c_out_valid), 64'd1);
    check("ft_data", 64'(c_out_data), 64'hAA);
    check("ft_ready", 64'(c_in_ready), 64'd1);
    tick();
    check("ft_count", 64'(c_count), 64'd0);
    check("ft_empty", 64'(c_empty), 64'd1);
    // Bypass shown while stalled, then the word is held in storage.
    c_in_data = 34'hBB; c_out_ready = 1'b0;
    #1 check("ft_stall_data", 64'(c_out_data), 64'hBB);
    tick();
    c_in_data = 34'hCC; c_out_ready = 1'b1;
    #1 check("ft_held_count", 64'(c_count), 64'd1);
    check("ft_held_data", 64'(c_out_data), 64'hBB);
    tick();
    c_in_valid = 1'b0;
    #1 check("ft_next_data", 64'(c_out_data), 64'hCC);
    check("ft_next_count", 64'(c_count), 64'd1);
    tick();
    check("ft_final_empty", 64'(c_empty), 64'd1);
    check("ft_final_valid", 64'(c_out_valid), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
